seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle 32-bit integer divider for the MIPS DIV/DIVU path. It produces the quotient (LO) and remainder (HI).
- It is the subtract-side counterpart of the datapath ripple adder. It runs a restoring shift/subtract loop, one quotient bit per clock.
- It sits beside the ALU. The controller starts it and stalls on DIV_busy until DIV_done.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- DIV_start  input  1  request; sampled only in IDLE or DONE
- DIV_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with DIV_start
- DIV_a  input  WIDTH  dividend; sampled with DIV_start
- DIV_b  input  WIDTH  divisor; sampled with DIV_start
- DIV_busy  output  1  high while the operation is in flight (RUN, FIX)
- DIV_done  output  1  one-cycle pulse; results valid from this cycle on
- DIV_quot  output  WIDTH  quotient, held until the next accepted start
- DIV_rem  output  WIDTH  remainder, held until the next accepted start
- DIV_by_zero  output  1  divisor was zero for the last operation; held with results

Behaviour:
- Reset: RESET is synchronous, active-high. While RESET is high at a rising edge:
  - state goes to IDLE and the counter clears;
  - DIV_busy=0, DIV_done=0, DIV_quot=0, DIV_rem=0, DIV_by_zero=0.
- Reset mid-operation: the operation is aborted, no DIV_done is issued, and all outputs go to zero.
- States: IDLE, RUN, FIX, DONE, all registered. All outputs are registered.
- IDLE, DIV_start=0: stay.
- IDLE, DIV_start=1 at edge k, DIV_b != 0:
  - latch operands;
  - if signed, take the magnitudes of a and b; record sign_q = a[MSB]^b[MSB] and sign_r = a[MSB];
  - rem_acc=0, quo_acc=|a|, cnt=WIDTH-1;
  - go to RUN; DIV_busy=1.
- IDLE, DIV_start=1, DIV_b == 0:
  - go to DONE at edge k+1;
  - DIV_quot = all ones, DIV_rem = DIV_a (raw, unmodified), DIV_by_zero=1;
  - DIV_busy stays 0.
- RUN, each cycle:
  - form trial = {rem_acc, quo_acc[MSB]} - {0, |b|}, WIDTH+1 bits with borrow;
  - if no borrow: rem_acc = trial low bits and the quotient bit is 1;
  - otherwise rem_acc is the shifted value and the quotient bit is 0;
  - quo_acc shifts left with the quotient bit in the LSB;
  - cnt decrements. When cnt==0, go to FIX.
- FIX, one cycle:
  - if signed, negate the quotient when sign_q=1 and negate the remainder when sign_r=1 (remainder takes the dividend's sign, truncating division);
  - load DIV_quot/DIV_rem, DIV_by_zero=0;
  - go to DONE.
- DONE:
  - DIV_done=1 for exactly this cycle; DIV_busy=0;
  - DIV_start=1 here is accepted exactly as in IDLE (back-to-back allowed); otherwise go to IDLE.
- Latency:
  - normal operation: DIV_done is high in the cycle after edge k+WIDTH+2, i.e. 34 clocks for WIDTH=32;
  - divide-by-zero: DIV_done follows edge k+1.
- DIV_start while busy (RUN/FIX) is ignored; no queueing.
- Signed overflow: 0x80000000 / -1 gives quot=0x80000000 and rem=0, by natural wrap of the negation. No flag is raised.
- Arithmetic rules:
  - magnitudes are computed in WIDTH bits; |0x80000000| stays 0x80000000, which is treated as an unsigned magnitude and is correct;
  - the trial subtract is WIDTH+1 bits, so no overflow occurs.
- Operand inputs are don't-care except on the accepting edge.

Decomposition:
- Shared package divider_pkg holds:
  - the WIDTH default;
  - the state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_FIX=2'd2, S_DONE=2'd3.
- Sub-module div_sub_stage: combinational WIDTH+1-bit trial subtractor. Inputs are the partial remainder, the shifted-in bit and the divisor. Outputs are the difference and no_borrow.
- The FSM, counter, sign fix-up and output registers live in seq_divider.

Test Plan:
- Unsigned basic: DIVU 100/7 -> DIV_done 34 clocks after start; quot=14, rem=2, by_zero=0, busy high for 33 cycles.
- Signed negative: DIV -7/2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Also 7/-2 -> quot=0xFFFFFFFD, rem=1.
- Divide by zero: DIVU 5/0 -> DIV_done one clock after start; quot=0xFFFFFFFF, rem=5, by_zero=1, busy never high.
- Signed overflow: DIV 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0. Also DIVU 0xFFFFFFFF/1 -> quot=0xFFFFFFFF, rem=0.
- Reset mid-run: RESET at RUN cycle 10 -> next cycle busy=0, quot=rem=0, and no done pulse ever follows. A subsequent DIVU 9/3 -> quot=3, rem=0.
- Start handling:
  - DIV_start pulsed during RUN is ignored (result equals the first operation's);
  - DIV_start in the DONE cycle launches a second divide whose done arrives 34 clocks later.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width default and FSM state encoding for the sequential divider
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// rtl/div_sub_stage.sv - WIDTH+1-bit trial subtract of the divisor from the shifted partial remainder
module div_sub_stage import divider_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_no_borrow
);

  logic w_borrow;
  logic w_spill;

  assign {w_borrow, w_spill, o_diff} = {1'b0, i_rem, i_bit} - {2'b00, i_div};

  // A non-negative result always fits WIDTH bits, so the spill bit is zero then.
  assign o_no_borrow = ~w_borrow & ~w_spill;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring shift/subtract divider for DIV/DIVU, one quotient bit per clock
module seq_divider import divider_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             DIV_start,
  input  logic             DIV_signed,
  input  logic [WIDTH-1:0] DIV_a,
  input  logic [WIDTH-1:0] DIV_b,
  output logic             DIV_busy,
  output logic             DIV_done,
  output logic [WIDTH-1:0] DIV_quot,
  output logic [WIDTH-1:0] DIV_rem,
  output logic             DIV_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem_acc;
  logic [WIDTH-1:0] r_quo_acc;
  logic [WIDTH-1:0] r_div;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_by_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_diff;
  logic             w_no_borrow;

  // |0x80000000| wraps to itself, which is still the right unsigned magnitude.
  assign w_abs_a = (DIV_signed && DIV_a[WIDTH-1]) ? -DIV_a : DIV_a;
  assign w_abs_b = (DIV_signed && DIV_b[WIDTH-1]) ? -DIV_b : DIV_b;

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .i_rem       (r_rem_acc),
    .i_bit       (r_quo_acc[WIDTH-1]),
    .i_div       (r_div),
    .o_diff      (w_diff),
    .o_no_borrow (w_no_borrow)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem_acc <= '0;
      r_quo_acc <= '0;
      r_div     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (!DIV_start) begin
            r_state <= S_IDLE;
          end else if (DIV_b == '0) begin
            r_quot    <= '1;
            r_rem     <= DIV_a;
            r_by_zero <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_sign_q  <= DIV_signed & (DIV_a[WIDTH-1] ^ DIV_b[WIDTH-1]);
            r_sign_r  <= DIV_signed & DIV_a[WIDTH-1];
            r_rem_acc <= '0;
            r_quo_acc <= w_abs_a;
            r_div     <= w_abs_b;
            r_cnt     <= CW'(WIDTH - 1);
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem_acc <= w_no_borrow ? w_diff : {r_rem_acc[WIDTH-2:0], r_quo_acc[WIDTH-1]};
          r_quo_acc <= {r_quo_acc[WIDTH-2:0], w_no_borrow};
          r_cnt     <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_FIX;
        end
        S_FIX: begin
          // Truncating division: the remainder follows the dividend's sign.
          r_quot    <= r_sign_q ? -r_quo_acc : r_quo_acc;
          r_rem     <= r_sign_r ? -r_rem_acc : r_rem_acc;
          r_by_zero <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end
      endcase
    end
  end

  assign DIV_busy    = r_busy;
  assign DIV_done    = r_done;
  assign DIV_quot    = r_quot;
  assign DIV_rem     = r_rem;
  assign DIV_by_zero = r_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DIV_start;
  logic        DIV_signed;
  logic [31:0] DIV_a;
  logic [31:0] DIV_b;
  logic        DIV_busy;
  logic        DIV_done;
  logic [31:0] DIV_quot;
  logic [31:0] DIV_rem;
  logic        DIV_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DIV_start   (DIV_start),
    .DIV_signed  (DIV_signed),
    .DIV_a       (DIV_a),
    .DIV_b       (DIV_b),
    .DIV_busy    (DIV_busy),
    .DIV_done    (DIV_done),
    .DIV_quot    (DIV_quot),
    .DIV_rem     (DIV_rem),
    .DIV_by_zero (DIV_by_zero)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    DIV_start  = 1'b1;
    DIV_signed = sgn;
    DIV_a      = a;
    DIV_b      = b;
  endtask

  // Counts edges from the drive point until done; optionally pokes a stray start mid-run.
  task automatic wait_op(input string tag, input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input int elat, input int poke_at);
    int lat = 0;
    int busy_cnt = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
      if (DIV_busy) busy_cnt++;
      DIV_start = (lat == poke_at);
      if (lat == poke_at) begin
        DIV_a = 32'd50;
        DIV_b = 32'd5;
      end
    end while (!DIV_done && lat < 100);
    DIV_start = 1'b0;
    check_val({tag, "_done"}, 32'(DIV_done), 32'd1);
    check_val({tag, "_lat"}, 32'(lat), 32'(elat));
    check_val({tag, "_busy"}, 32'(busy_cnt), (elat == 1) ? 32'd0 : 32'(elat - 1));
    check_val({tag, "_quot"}, DIV_quot, eq);
    check_val({tag, "_rem"}, DIV_rem, er);
    check_val({tag, "_zero"}, 32'(DIV_by_zero), 32'(ez));
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez, input int elat);
    @(negedge CLK);
    drive_op(sgn, a, b);
    wait_op(tag, eq, er, ez, elat, -1);
  endtask

  initial begin
    int done_seen;
    RESET      = 1'b1;
    DIV_start  = 1'b0;
    DIV_signed = 1'b0;
    DIV_a      = 32'd0;
    DIV_b      = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check_val("rst_busy", 32'(DIV_busy), 32'd0);
    check_val("rst_done", 32'(DIV_done), 32'd0);
    check_val("rst_quot", DIV_quot, 32'd0);
    check_val("rst_rem", DIV_rem, 32'd0);
    check_val("rst_zero", 32'(DIV_by_zero), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    @(posedge CLK);
    #1;
    check_val("done_pulse", 32'(DIV_done), 32'd0);
    check_val("held_quot", DIV_quot, 32'd14);

    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
    run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 34);

    // Stray start during RUN must not disturb the 100/7 result.
    @(negedge CLK);
    drive_op(1'b0, 32'd100, 32'd7);
    wait_op("ignore_start", 32'd14, 32'd2, 1'b0, 34, 5);

    // Back-to-back: second start presented in the DONE cycle.
    @(negedge CLK);
    drive_op(1'b0, 32'd1000, 32'd10);
    wait_op("b2b_first", 32'd100, 32'd0, 1'b0, 34, -1);
    drive_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_op("b2b_second", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, -1);

    // Reset in the middle of RUN.
    @(negedge CLK);
    drive_op(1'b0, 32'd100, 32'd7);
    @(posedge CLK);
    #1;
    DIV_start = 1'b0;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check_val("mid_rst_busy", 32'(DIV_busy), 32'd0);
    check_val("mid_rst_quot", DIV_quot, 32'd0);
    check_val("mid_rst_rem", DIV_rem, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (DIV_done) done_seen++;
    end
    check_val("mid_rst_no_done", 32'(done_seen), 32'd0);
    run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
